// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: receive holding-register bus between the UART receive
// front end (master) and the peripheral that consumes bytes (slave).
//   rd_ack      peripheral -> front end, one-cycle "byte consumed, clear flags"
//   rx_data     last accepted byte
//   rx_valid    rx_data holds an unread byte
//   overrun     sticky: a completed byte was dropped because rx_valid was set
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: even-parity mismatch (tied low without parity build)
//   busy        a frame is being received
interface uart_rx_frontend_if;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rd_ack,
        output rx_data, rx_valid, overrun, frame_err, parity_err, busy
    );

    modport slave (
        output rd_ack,
        input  rx_data, rx_valid, overrun, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronises the raw serial line and recovers 8-bit async
// frames with 16x oversampling into a single-entry holding register.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (PARITY state and a
// live parity_err); otherwise frames are 8N1 and parity_err is tied low.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   din    raw serial line, idle high, asynchronous to clk
//   bus    uart_rx_frontend_if.master (rd_ack in; data, flags, busy out)
// Parameters: CLK_HZ, BAUD; DIV = CLK_HZ/(BAUD*16) must be at least 1.
module uart_rx_frontend #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    uart_rx_frontend_if.master bus
);
    localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW  = 8;
    localparam int unsigned OSW = 4;
    localparam int unsigned BW  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state_q, state_n;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [OSW-1:0]  os_q, os_n;
    logic [BW-1:0]   bit_q, bit_n;
    logic [DW-1:0]   sh_q, sh_n;
    logic [DW-1:0]   data_q, data_n;
    logic            valid_q, valid_n;
    logic            ovr_q, ovr_n;
    logic            ferr_q, ferr_n;
    logic            perr_q, perr_n;
    logic            busy_q, busy_n;
    logic            rxs;
    logic            tick;
    logic            par_bad;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_n;
`endif

    assign rxs = sync_q[1];

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    assign par_bad = par_q ^ (^sh_q);
`else
    assign par_bad = 1'b0;
`endif

    // State and datapath registers; the synchroniser resets to line-idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            sync_q  <= {sync_q[0], din};
            cnt_q   <= cnt_n;
            os_q    <= os_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ovr_q   <= ovr_n;
            ferr_q  <= ferr_n;
            perr_q  <= perr_n;
            busy_q  <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // Next-state, tick generation and holding-register update.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        os_n    = os_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        data_n  = data_q;
        valid_n = valid_q;
        ovr_n   = ovr_q;
        ferr_n  = ferr_q;
        perr_n  = perr_q;
        tick    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
`endif

        // Divider is parked at zero while idle so the first tick is aligned
        // to the start-edge detection.
        if (state_q == IDLE) begin
            cnt_n = '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_n = '0;
            tick  = 1'b1;
        end else begin
            cnt_n = cnt_q + CW'(1);
        end

        if (tick) begin
            os_n = os_q + OSW'(1);
        end

        // Acknowledge clears first; a load or error set below overrides it.
        if (bus.rd_ack) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
            ferr_n  = 1'b0;
            perr_n  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                os_n  = '0;
                bit_n = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (tick && (os_q == OSW'(7))) begin
                    os_n    = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && (os_q == OSW'(15))) begin
                    sh_n[bit_q] = rxs;
                    bit_n       = bit_q + BW'(1);
                    if (bit_q == BW'(7)) begin
                        os_n    = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && (os_q == OSW'(15))) begin
                    par_n   = rxs;
                    os_n    = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && (os_q == OSW'(15))) begin
                    os_n    = '0;
                    state_n = IDLE;
                    if (!rxs) begin
                        ferr_n = 1'b1;
                    end else if (par_bad) begin
                        perr_n = 1'b1;
                    end else if (!valid_q || bus.rd_ack) begin
                        data_n  = sh_q;
                        valid_n = 1'b1;
                    end else begin
                        ovr_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy_n = (state_n != IDLE);

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.busy       = busy_q;
endmodule
